// File: rtl/midi_pkg.sv
// Shared MIDI framing definitions: parser states, status-class constants and
// the data-byte count lookup used by the message parser.
package midi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_D1,
      ST_WAIT_D2,
      ST_SYSEX
   } parser_state_t;

   localparam logic [7:0] MIDI_SYSEX        = 8'hF0;
   localparam logic [7:0] MIDI_EOX          = 8'hF7;
   localparam logic [7:0] MIDI_ACTIVE_SENSE = 8'hFE;
   localparam logic [7:0] MIDI_RT_BASE      = 8'hF8;

   function automatic logic [1:0] midi_data_len(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd0;
      case (status[7:4])
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
         4'hC, 4'hD:                   len = 2'd1;
         4'hF: begin
            if (status == 8'hF2)
               len = 2'd2;
            else if (status == 8'hF1 || status == 8'hF3)
               len = 2'd1;
         end
         default: len = 2'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/midi_msg_outreg.sv
// Single-entry valid/ready message holding register; a message arriving while
// the held one is neither empty nor being accepted is dropped and flagged.
module midi_msg_outreg
   import midi_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] loadStatus,
   input  logic [6:0] loadData1,
   input  logic [6:0] loadData2,
   input  logic [1:0] loadLen,
   input  logic       msgReady,
   output logic       msgValid,
   output logic [7:0] msgStatus,
   output logic [6:0] msgData1,
   output logic [6:0] msgData2,
   output logic [1:0] msgLen,
   output logic       overflow
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         msgValid  <= 1'b0;
         msgStatus <= '0;
         msgData1  <= '0;
         msgData2  <= '0;
         msgLen    <= '0;
         overflow  <= 1'b0;
      end else if (load) begin
         if (!msgValid || msgReady) begin
            msgValid  <= 1'b1;
            msgStatus <= loadStatus;
            msgData1  <= loadData1;
            msgData2  <= loadData2;
            msgLen    <= loadLen;
         end else begin
            overflow  <= 1'b1;
         end
      end else if (msgValid && msgReady) begin
         msgValid <= 1'b0;
      end
   end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-to-message framer: running status, real-time interleave and SysEx
// bracketing, feeding a single-entry valid/ready output register.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter bit FILTER_ACTIVE_SENSE = 1'b0,
   parameter bit RUNNING_STATUS_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] rx_data,
   input  logic       rx_data_ready,
   output logic       msg_valid,
   input  logic       msg_ready,
   output logic [7:0] msg_status,
   output logic [6:0] msg_data1,
   output logic [6:0] msg_data2,
   output logic [1:0] msg_len,
   output logic       sysex_active,
   output logic       overflow,
   output logic       err_strobe
);

   parser_state_t state, stateNext;
   logic [7:0] curStatus, statusNext;
   logic [6:0] d1, d1Next;
   logic       errNext;
   logic       msgDone;
   logic       emit;
   logic [7:0] emStatus;
   logic [6:0] emD1, emD2;
   logic [1:0] emLen;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         curStatus  <= '0;
         d1         <= '0;
         err_strobe <= 1'b0;
      end else begin
         state      <= stateNext;
         curStatus  <= statusNext;
         d1         <= d1Next;
         err_strobe <= errNext;
      end
   end

   always_comb begin
      stateNext  = state;
      statusNext = curStatus;
      d1Next     = d1;
      errNext    = 1'b0;
      msgDone    = 1'b0;
      emit       = 1'b0;
      emStatus   = '0;
      emD1       = '0;
      emD2       = '0;
      emLen      = '0;
      if (rx_data_ready) begin
         if (rx_data >= MIDI_RT_BASE) begin
            // Real-time bytes bypass the parser state entirely.
            if (rx_data == 8'hF9 || rx_data == 8'hFD)
               errNext = 1'b1;
            else if (!(FILTER_ACTIVE_SENSE && rx_data == MIDI_ACTIVE_SENSE)) begin
               emit     = 1'b1;
               emStatus = rx_data;
               emLen    = 2'd1;
            end
         end else if (!rx_data[7]) begin
            case (state)
               ST_IDLE: errNext = 1'b1;
               ST_WAIT_D1: begin
                  if (midi_data_len(curStatus) == 2'd2) begin
                     d1Next    = rx_data[6:0];
                     stateNext = ST_WAIT_D2;
                  end else begin
                     emit     = 1'b1;
                     emStatus = curStatus;
                     emD1     = rx_data[6:0];
                     emLen    = 2'd2;
                     msgDone  = 1'b1;
                  end
               end
               ST_WAIT_D2: begin
                  emit     = 1'b1;
                  emStatus = curStatus;
                  emD1     = d1;
                  emD2     = rx_data[6:0];
                  emLen    = 2'd3;
                  msgDone  = 1'b1;
               end
               default: ;
            endcase
         end else begin
            // Any non-real-time status ends SysEx and is then handled as from IDLE.
            stateNext  = ST_IDLE;
            statusNext = '0;
            case (rx_data)
               MIDI_SYSEX:   stateNext = ST_SYSEX;
               MIDI_EOX:     errNext   = (state != ST_SYSEX);
               8'hF4, 8'hF5: errNext   = 1'b1;
               8'hF6: begin
                  emit     = 1'b1;
                  emStatus = rx_data;
                  emLen    = 2'd1;
               end
               default: begin
                  statusNext = rx_data;
                  stateNext  = ST_WAIT_D1;
               end
            endcase
         end
      end
      if (msgDone) begin
         if (curStatus >= MIDI_SYSEX || !RUNNING_STATUS_EN) begin
            stateNext  = ST_IDLE;
            statusNext = '0;
         end else begin
            stateNext  = ST_WAIT_D1;
         end
      end
   end

   assign sysex_active = (state == ST_SYSEX);

   midi_msg_outreg u_outreg (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (emit),
      .loadStatus (emStatus),
      .loadData1  (emD1),
      .loadData2  (emD2),
      .loadLen    (emLen),
      .msgReady   (msg_ready),
      .msgValid   (msg_valid),
      .msgStatus  (msg_status),
      .msgData1   (msg_data1),
      .msgData2   (msg_data2),
      .msgLen     (msg_len),
      .overflow   (overflow)
   );

endmodule
